isdu_param: RTL and testbench

Parametrised LC-3 instruction sequencer/decoder for the lab datapath. It drives the same load, gate and mux controls as the existing sequencer. Memory-access length is configurable: either a fixed wait count or a Mem_Ready handshake. It also adds single-state JSR/JSRR, full STR and NOT support, and an illegal-opcode flag. Sits between IR/BEN/NZP logic and the datapath/SRAM interface.

---
 rtl/isdu_param.sv | 230 +++++++++++++++++++++++
 tb/tb_isdu_param.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/isdu_param.sv
// LC-3 instruction sequencer/decoder with a configurable memory-access length:
// either a fixed wait count per memory state or a Mem_Ready handshake.
module isdu_param #(
  parameter int MEM_WAIT  = 3,
  parameter int USE_READY = 0,
  parameter int PAUSE_LED = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  input  logic       Mem_Ready,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic       Illegal_Op
);

  localparam int CntW = $clog2(MEM_WAIT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(MEM_WAIT - 1);

  typedef enum logic [4:0] {
    HALTED,
    FETCH_MAR,
    FETCH_MEM,
    FETCH_IR,
    DECODE,
    S_ADD,
    S_AND,
    S_NOT,
    LDR_ADDR,
    LDR_MEM,
    LDR_WB,
    STR_ADDR,
    STR_MDR,
    STR_MEM,
    S_JSR,
    S_JMP,
    S_BR,
    BR_TAKE,
    PAUSE1,
    PAUSE2
  } state_t;

  state_t          state_q, state_d;
  logic [CntW-1:0] waitCnt_q, waitCnt_d;
  logic            memDone;
  logic [CntW-1:0] cntStep;
  logic            legalOp;

  // A memory state finishes either on the handshake or when the counter hits its last cycle.
  assign memDone = (USE_READY != 0) ? Mem_Ready : (waitCnt_q == LastCnt);
  assign cntStep = (USE_READY != 0) ? '0 : waitCnt_q + 1'b1;
  assign legalOp = Opcode inside {4'b0001, 4'b0101, 4'b1001, 4'b0110, 4'b0111,
                                  4'b0100, 4'b1100, 4'b0000, 4'b1101};

  always_comb begin
    state_d   = state_q;
    waitCnt_d = '0;
    case (state_q)
      HALTED:    if (Run) state_d = FETCH_MAR;
      FETCH_MAR: state_d = FETCH_MEM;
      FETCH_MEM: begin
        if (memDone) state_d = FETCH_IR;
        else waitCnt_d = cntStep;
      end
      FETCH_IR:  state_d = DECODE;
      DECODE: begin
        case (Opcode)
          4'b0001: state_d = S_ADD;
          4'b0101: state_d = S_AND;
          4'b1001: state_d = S_NOT;
          4'b0110: state_d = LDR_ADDR;
          4'b0111: state_d = STR_ADDR;
          4'b0100: state_d = S_JSR;
          4'b1100: state_d = S_JMP;
          4'b0000: state_d = S_BR;
          4'b1101: state_d = PAUSE1;
          default: state_d = FETCH_MAR;
        endcase
      end
      S_ADD, S_AND, S_NOT: state_d = FETCH_MAR;
      LDR_ADDR:  state_d = LDR_MEM;
      LDR_MEM: begin
        if (memDone) state_d = LDR_WB;
        else waitCnt_d = cntStep;
      end
      LDR_WB:    state_d = FETCH_MAR;
      STR_ADDR:  state_d = STR_MDR;
      STR_MDR:   state_d = STR_MEM;
      STR_MEM: begin
        if (memDone) state_d = FETCH_MAR;
        else waitCnt_d = cntStep;
      end
      S_JSR, S_JMP: state_d = FETCH_MAR;
      S_BR:      state_d = BEN ? BR_TAKE : FETCH_MAR;
      BR_TAKE:   state_d = FETCH_MAR;
      PAUSE1:    if (Continue) state_d = PAUSE2;
      PAUSE2:    if (!Continue) state_d = FETCH_MAR;
      default:   state_d = HALTED;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= HALTED;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  always_comb begin
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = 2'b00;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'b00;
    ALUK       = 2'b00;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;
    Illegal_Op = 1'b0;
    case (state_q)
      FETCH_MAR: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC  = 1'b1;
      end
      FETCH_MEM, LDR_MEM: begin
        Mem_OE = 1'b1;
        LD_MDR = memDone;
      end
      FETCH_IR: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      DECODE: begin
        LD_BEN     = 1'b1;
        Illegal_Op = !legalOp;
      end
      S_ADD, S_AND, S_NOT: begin
        SR1MUX  = 1'b1;
        SR2MUX  = IR_5;
        ALUK    = (state_q == S_AND) ? 2'b01 : (state_q == S_NOT) ? 2'b10 : 2'b00;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      LDR_ADDR, STR_ADDR: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = 2'b01;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
      end
      LDR_WB: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      STR_MDR: begin
        ALUK    = 2'b11;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
      end
      STR_MEM: Mem_WE = 1'b1;
      // Old PC goes to R7 on the bus while the target is loaded from the address adder.
      S_JSR: begin
        GatePC   = 1'b1;
        DRMUX    = 1'b1;
        LD_REG   = 1'b1;
        PCMUX    = 2'b01;
        LD_PC    = 1'b1;
        ADDR1MUX = !IR_11;
        SR1MUX   = !IR_11;
        ADDR2MUX = IR_11 ? 2'b11 : 2'b00;
      end
      S_JMP: begin
        SR1MUX   = 1'b1;
        ADDR1MUX = 1'b1;
        PCMUX    = 2'b01;
        LD_PC    = 1'b1;
      end
      BR_TAKE: begin
        ADDR2MUX = 2'b10;
        PCMUX    = 2'b01;
        LD_PC    = 1'b1;
      end
      PAUSE1, PAUSE2: LD_LED = (PAUSE_LED != 0);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_isdu_param.sv
// Directed bench for isdu_param: three instances (fixed wait 3, fixed wait 2,
// ready handshake) share the inputs; each scenario inspects one of them.
module tb_isdu_param;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Run = 1'b0;
  logic       Continue = 1'b0;
  logic [3:0] Opcode = 4'h0;
  logic       IR_5 = 1'b0;
  logic       IR_11 = 1'b0;
  logic       BEN = 1'b0;
  logic       Mem_Ready = 1'b0;

  wire [25:0] cwArr [3];
  int checks = 0;
  int passes = 0;
  int invErr = 0;
  bit invOn = 1'b0;

  always #5 Clk = ~Clk;

  // Control word: loads, gates, muxes, strobes, Illegal_Op, spare zero bit.
  localparam logic [25:0] LDMAR   = 26'd1 << 25;
  localparam logic [25:0] LDMDR   = 26'd1 << 24;
  localparam logic [25:0] LDIR    = 26'd1 << 23;
  localparam logic [25:0] LDBEN   = 26'd1 << 22;
  localparam logic [25:0] LDCC    = 26'd1 << 21;
  localparam logic [25:0] LDREG   = 26'd1 << 20;
  localparam logic [25:0] LDPC    = 26'd1 << 19;
  localparam logic [25:0] LDLED   = 26'd1 << 18;
  localparam logic [25:0] GPC     = 26'd1 << 17;
  localparam logic [25:0] GMDR    = 26'd1 << 16;
  localparam logic [25:0] GALU    = 26'd1 << 15;
  localparam logic [25:0] GMAR    = 26'd1 << 14;
  localparam logic [25:0] PCADD   = 26'd1 << 12;
  localparam logic [25:0] DR7     = 26'd1 << 11;
  localparam logic [25:0] SR1     = 26'd1 << 10;
  localparam logic [25:0] SR2     = 26'd1 << 9;
  localparam logic [25:0] A1      = 26'd1 << 8;
  localparam logic [25:0] A2OFF6  = 26'd1 << 6;
  localparam logic [25:0] A2OFF9  = 26'd2 << 6;
  localparam logic [25:0] A2OFF11 = 26'd3 << 6;
  localparam logic [25:0] KAND    = 26'd1 << 4;
  localparam logic [25:0] KNOT    = 26'd2 << 4;
  localparam logic [25:0] KPASS   = 26'd3 << 4;
  localparam logic [25:0] OE      = 26'd1 << 3;
  localparam logic [25:0] WE      = 26'd1 << 2;
  localparam logic [25:0] ILL     = 26'd1 << 1;

  localparam logic [25:0] FETCHW = GPC | LDMAR | LDPC;
  localparam logic [25:0] ALUW   = SR1 | GALU | LDREG | LDCC;
  localparam logic [25:0] ADDRW  = SR1 | A1 | A2OFF6 | GMAR | LDMAR;
  localparam logic [25:0] JSRW   = GPC | DR7 | LDREG | PCADD | LDPC;

  for (genvar g = 0; g < 3; g++) begin : gDut
    logic ldMar, ldMdr, ldIr, ldBen, ldCc, ldReg, ldPc, ldLed;
    logic gPc, gMdr, gAlu, gMar, drMux, sr1Mux, sr2Mux, a1Mux, memOe, memWe, illOp;
    logic [1:0] pcMux, a2Mux, aluk;

    isdu_param #(
      .MEM_WAIT (g == 0 ? 3 : (g == 1 ? 2 : 1)),
      .USE_READY(g == 2 ? 1 : 0),
      .PAUSE_LED(1)
    ) dut (
      .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
      .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN), .Mem_Ready(Mem_Ready),
      .LD_MAR(ldMar), .LD_MDR(ldMdr), .LD_IR(ldIr), .LD_BEN(ldBen),
      .LD_CC(ldCc), .LD_REG(ldReg), .LD_PC(ldPc), .LD_LED(ldLed),
      .GatePC(gPc), .GateMDR(gMdr), .GateALU(gAlu), .GateMARMUX(gMar),
      .PCMUX(pcMux), .DRMUX(drMux), .SR1MUX(sr1Mux), .SR2MUX(sr2Mux),
      .ADDR1MUX(a1Mux), .ADDR2MUX(a2Mux), .ALUK(aluk),
      .Mem_OE(memOe), .Mem_WE(memWe), .Illegal_Op(illOp)
    );

    assign cwArr[g] = {ldMar, ldMdr, ldIr, ldBen, ldCc, ldReg, ldPc, ldLed,
                       gPc, gMdr, gAlu, gMar, pcMux, drMux, sr1Mux, sr2Mux,
                       a1Mux, a2Mux, aluk, memOe, memWe, illOp, 1'b0};
  end

  // Bus and strobe exclusivity must hold on every cycle of every instance.
  always @(negedge Clk) begin
    if (invOn) begin
      for (int k = 0; k < 3; k++) begin
        if ($countones(cwArr[k][17:14]) > 1 || (cwArr[k][3] && cwArr[k][2])) invErr++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic ir5, input logic ir11, input logic ben);
    Opcode = op;
    IR_5   = ir5;
    IR_11  = ir11;
    BEN    = ben;
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Reset, pulse Run, then walk through fetch so the instance sits in DECODE.
  task automatic startToDecode(input int memCycles);
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    Run = 1'b1;
    tick;
    Run = 1'b0;
    repeat (memCycles + 2) tick;
  endtask

  initial begin
    // ADD immediate (0x1262) on the MEM_WAIT=3 instance
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
    tick;
    Reset = 1'b0;
    invOn = 1'b1;
    checkOutput("halted", cwArr[0], 0);
    Run = 1'b1;
    tick;
    Run = 1'b0;
    checkOutput("add fetch_mar", cwArr[0], FETCHW);
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput("add fetch_mem", cwArr[0], (i == 2) ? (OE | LDMDR) : OE);
    end
    tick; checkOutput("add fetch_ir", cwArr[0], GMDR | LDIR);
    tick; checkOutput("add decode", cwArr[0], LDBEN);
    tick; checkOutput("add exec", cwArr[0], ALUW | SR2);
    tick; checkOutput("add back fetch", cwArr[0], FETCHW);

    // LDR (0x6A42) on the ready-handshake instance
    applyStimulus(4'b0110, 1'b0, 1'b1, 1'b0);
    Mem_Ready = 1'b1;
    Reset = 1'b1; tick; Reset = 1'b0;
    Run = 1'b1; tick; Run = 1'b0;
    checkOutput("rdy fetch_mar", cwArr[2], FETCHW);
    tick; checkOutput("rdy fetch_mem 1cyc", cwArr[2], OE | LDMDR);
    tick; checkOutput("rdy fetch_ir", cwArr[2], GMDR | LDIR);
    tick; checkOutput("rdy decode", cwArr[2], LDBEN);
    tick; checkOutput("ldr addr", cwArr[2], ADDRW);
    Mem_Ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      checkOutput("ldr mem wait", cwArr[2], OE);
    end
    tick;
    Mem_Ready = 1'b1;
    #1;
    checkOutput("ldr mem ready", cwArr[2], OE | LDMDR);
    tick; checkOutput("ldr wb", cwArr[2], GMDR | LDREG | LDCC);
    tick; checkOutput("ldr back fetch", cwArr[2], FETCHW);

    // STR (0x7A42) on the MEM_WAIT=2 instance
    applyStimulus(4'b0111, 1'b0, 1'b1, 1'b0);
    Reset = 1'b1; tick; Reset = 1'b0;
    Run = 1'b1; tick; Run = 1'b0;
    checkOutput("str fetch_mar", cwArr[1], FETCHW);
    tick; checkOutput("str fetch_mem c0", cwArr[1], OE);
    tick; checkOutput("str fetch_mem c1", cwArr[1], OE | LDMDR);
    tick; checkOutput("str fetch_ir", cwArr[1], GMDR | LDIR);
    tick; checkOutput("str decode", cwArr[1], LDBEN);
    tick; checkOutput("str addr", cwArr[1], ADDRW);
    tick; checkOutput("str mdr", cwArr[1], KPASS | GALU | LDMDR);
    tick; checkOutput("str mem c0", cwArr[1], WE);
    tick; checkOutput("str mem c1", cwArr[1], WE);
    tick; checkOutput("str back fetch", cwArr[1], FETCHW);

    // JSR (0x4805) and JSRR (0x4080)
    applyStimulus(4'b0100, 1'b0, 1'b1, 1'b0);
    startToDecode(3);
    checkOutput("jsr decode", cwArr[0], LDBEN);
    tick; checkOutput("jsr exec", cwArr[0], JSRW | A2OFF11);
    tick; checkOutput("jsr back fetch", cwArr[0], FETCHW);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    startToDecode(3);
    tick; checkOutput("jsrr exec", cwArr[0], JSRW | A1 | SR1);
    tick; checkOutput("jsrr back fetch", cwArr[0], FETCHW);

    // Illegal opcode 1010
    applyStimulus(4'b1010, 1'b0, 1'b0, 1'b0);
    startToDecode(3);
    checkOutput("illegal decode", cwArr[0], LDBEN | ILL);
    tick; checkOutput("illegal to fetch", cwArr[0], FETCHW);

    // BR not taken, then taken
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    startToDecode(3);
    tick; checkOutput("br nt state", cwArr[0], 0);
    tick; checkOutput("br nt fetch", cwArr[0], FETCHW);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
    startToDecode(3);
    tick; checkOutput("br t state", cwArr[0], 0);
    tick; checkOutput("br take", cwArr[0], A2OFF9 | PCADD | LDPC);
    tick; checkOutput("br t fetch", cwArr[0], FETCHW);

    // AND register, NOT, JMP
    applyStimulus(4'b0101, 1'b0, 1'b0, 1'b0);
    startToDecode(3);
    tick; checkOutput("and exec", cwArr[0], ALUW | KAND);
    applyStimulus(4'b1001, 1'b1, 1'b0, 1'b0);
    startToDecode(3);
    tick; checkOutput("not exec", cwArr[0], ALUW | KNOT | SR2);
    applyStimulus(4'b1100, 1'b0, 1'b0, 1'b0);
    startToDecode(3);
    tick; checkOutput("jmp exec", cwArr[0], SR1 | A1 | PCADD | LDPC);
    tick; checkOutput("jmp back fetch", cwArr[0], FETCHW);

    // Reset in the middle of STR_MEM, then a clean restart
    applyStimulus(4'b0111, 1'b0, 1'b0, 1'b0);
    startToDecode(2);
    tick; tick; tick;
    checkOutput("str mem before reset", cwArr[1], WE);
    Reset = 1'b1;
    tick;
    checkOutput("reset mid str", cwArr[1], 0);
    Reset = 1'b0;
    repeat (3) tick;
    checkOutput("no fetch without run", cwArr[1], 0);
    Run = 1'b1; tick; Run = 1'b0;
    checkOutput("restart fetch_mar", cwArr[1], FETCHW);
    tick; checkOutput("restart cnt cleared", cwArr[1], OE);
    tick; checkOutput("restart mem last", cwArr[1], OE | LDMDR);

    // PAUSE with Continue high then low
    applyStimulus(4'b1101, 1'b0, 1'b0, 1'b0);
    Continue = 1'b0;
    startToDecode(3);
    tick; checkOutput("pause1 enter", cwArr[0], LDLED);
    tick; checkOutput("pause1 hold", cwArr[0], LDLED);
    Continue = 1'b1;
    tick; checkOutput("pause2 enter", cwArr[0], LDLED);
    tick; checkOutput("pause2 hold", cwArr[0], LDLED);
    Continue = 1'b0;
    tick; checkOutput("pause release", cwArr[0], FETCHW);

    checkOutput("invariants", invErr, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
